// File: rtl/wb_spi_pkg.sv
// Shared register map, CTRL field positions and shift-engine state encoding
// for the Wishbone SPI master.
package wb_spi_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_TX     = 2'd2;
  localparam logic [1:0] REG_RX     = 2'd3;

  localparam int CTRL_CPOL    = 8;
  localparam int CTRL_CPHA    = 9;
  localparam int CTRL_SSM     = 10;
  localparam int CTRL_SS_LSB  = 11;
  localparam int CTRL_LEN_LSB = 19;

  typedef logic [1:0] spi_state_t;

  localparam spi_state_t ST_IDLE  = 2'd0;
  localparam spi_state_t ST_SETUP = 2'd1;
  localparam spi_state_t ST_XFER  = 2'd2;
  localparam spi_state_t ST_HOLD  = 2'd3;

  // Lengths at or beyond the datapath width fall back to a full-width word.
  function automatic logic [4:0] clamp_len(input logic [4:0] len, input int data_w);
    return ({1'b0, len} >= 6'(data_w)) ? 5'(data_w - 1) : len;
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// SPI bit engine: SCK divider, SETUP/XFER/HOLD sequencing, MOSI shift-out
// and MISO shift-in for all four CPOL/CPHA modes.
module spi_shift_engine
  import wb_spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4:0]        len,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DIV_W-1:0]  div,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              miso,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx,
  output logic              sck,
  output logic              mosi,
  output logic              ss_active
);

  spi_state_t        state;
  logic [DIV_W-1:0]  cnt;
  logic [6:0]        edges;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic              sck_r;

  logic              tick;
  logic              leading;
  logic              sample_edge;
  logic              last_edge;
  logic [6:0]        edge_total;
  logic [4:0]        align_sh;
  logic [DATA_W-1:0] tx_aligned;

  assign tick        = (cnt == '0);
  assign leading     = ~edges[0];
  // cpha=0 samples on leading edges, cpha=1 on trailing edges.
  assign sample_edge = leading ^ cpha;
  assign edge_total  = {1'b0, len, 1'b0} + 7'd2;
  assign last_edge   = ((edges + 7'd1) == edge_total);
  assign align_sh    = 5'(DATA_W - 1) - len;
  assign tx_aligned  = tx_data << align_sh;

  assign busy      = (state != ST_IDLE);
  assign ss_active = busy;
  assign sck       = busy ? sck_r : cpol;
  assign rx        = rx_sh;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      edges <= '0;
      tx_sh <= '0;
      rx_sh <= '0;
      sck_r <= 1'b0;
      mosi  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_SETUP;
            cnt   <= div;
            edges <= '0;
            rx_sh <= '0;
            sck_r <= cpol;
            // cpha=0 presents the MSB before the first edge; cpha=1 waits for it.
            if (!cpha) begin
              mosi  <= tx_aligned[DATA_W-1];
              tx_sh <= tx_aligned << 1;
            end else begin
              tx_sh <= tx_aligned;
            end
          end
        end
        ST_SETUP, ST_XFER: begin
          if (tick) begin
            cnt   <= div;
            sck_r <= ~sck_r;
            edges <= edges + 7'd1;
            if (sample_edge) rx_sh <= {rx_sh[DATA_W-2:0], miso};
            if (!sample_edge && !last_edge) begin
              mosi  <= tx_sh[DATA_W-1];
              tx_sh <= tx_sh << 1;
            end
            state <= last_edge ? ST_HOLD : ST_XFER;
          end else begin
            cnt <= cnt - DIV_W'(1);
          end
        end
        ST_HOLD: begin
          if (tick) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - DIV_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/wb_spi_master.sv
// Wishbone register file for the SPI master: CTRL/STATUS/TX/RX registers,
// single-cycle-delayed ack and slave-select muxing around the shift engine.
module wb_spi_master
  import wb_spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 4,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       wb_addr,
  input  logic              wb_we,
  input  logic              wb_stb,
  input  logic              wb_cyc,
  input  logic [31:0]       wb_dout,
  output logic [31:0]       wb_din,
  output logic              wb_ack,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_SS-1:0] spi_ss
);

  logic [DIV_W-1:0]  div_q;
  logic              cpol_q;
  logic              cpha_q;
  logic              ssm_q;
  logic [7:0]        ss_sel_q;
  logic [4:0]        len_q;
  logic              wr_err_q;
  logic              rx_valid_q;
  logic [DATA_W-1:0] rx_data_q;

  logic              acc;
  logic              wr;
  logic              rd;
  logic [1:0]        addr;
  logic              start;
  logic              busy;
  logic              done;
  logic              eng_ss;
  logic [DATA_W-1:0] eng_rx;
  logic [31:0]       rdata;
  logic              unused_bits;

  assign acc   = wb_cyc & wb_stb & ~wb_ack;
  assign wr    = acc & wb_we;
  assign rd    = acc & ~wb_we;
  assign addr  = wb_addr[3:2];
  assign start = wr && (addr == REG_TX) && !busy;

  assign unused_bits = ^{wb_addr[31:4], wb_addr[1:0], wb_dout[31:24]};

  spi_shift_engine #(
    .DATA_W (DATA_W),
    .DIV_W  (DIV_W)
  ) u_engine (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (clamp_len(len_q, DATA_W)),
    .cpol      (cpol_q),
    .cpha      (cpha_q),
    .div       (div_q),
    .tx_data   (wb_dout[DATA_W-1:0]),
    .miso      (spi_miso),
    .busy      (busy),
    .done      (done),
    .rx        (eng_rx),
    .sck       (spi_sck),
    .mosi      (spi_mosi),
    .ss_active (eng_ss)
  );

  // Manual mode drives the selects continuously, even with the engine idle.
  always_comb begin
    spi_ss = '1;
    if (ssm_q || eng_ss) spi_ss = ~ss_sel_q[NUM_SS-1:0];
  end

  always_comb begin
    rdata = '0;
    case (addr)
      REG_CTRL: begin
        rdata[DIV_W-1:0]                = div_q;
        rdata[CTRL_CPOL]                = cpol_q;
        rdata[CTRL_CPHA]                = cpha_q;
        rdata[CTRL_SSM]                 = ssm_q;
        rdata[CTRL_SS_LSB +: 8]         = ss_sel_q;
        rdata[CTRL_LEN_LSB +: 5]        = len_q;
      end
      REG_STATUS: rdata[2:0]            = {wr_err_q, rx_valid_q, busy};
      REG_RX:     rdata[DATA_W-1:0]     = rx_data_q;
      default:    rdata                 = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_ack     <= 1'b0;
      wb_din     <= '0;
      div_q      <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      ssm_q      <= 1'b0;
      ss_sel_q   <= '0;
      len_q      <= 5'(DATA_W - 1);
      wr_err_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      wb_ack <= acc;
      wb_din <= rd ? rdata : '0;

      if (wr && (addr == REG_CTRL) && !busy) begin
        div_q    <= wb_dout[DIV_W-1:0];
        cpol_q   <= wb_dout[CTRL_CPOL];
        cpha_q   <= wb_dout[CTRL_CPHA];
        ssm_q    <= wb_dout[CTRL_SSM];
        ss_sel_q <= wb_dout[CTRL_SS_LSB +: 8];
        len_q    <= wb_dout[CTRL_LEN_LSB +: 5];
      end

      if (wr && (addr == REG_TX) && busy) wr_err_q <= 1'b1;
      else if (wr && (addr == REG_STATUS) && wb_dout[2]) wr_err_q <= 1'b0;

      // A completing transfer wins over a coincident RXDATA read.
      if (done) begin
        rx_valid_q <= 1'b1;
        rx_data_q  <= eng_rx;
      end else if (rd && (addr == REG_RX)) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_spi_master.sv
// Self-checking bench for wb_spi_master: a timing/slave model driven from the
// programmed register values is compared against the SPI pins every cycle.
module tb_wb_spi_master;

  localparam int DATA_W = 16;
  localparam int NUM_SS = 4;
  localparam int DIV_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [31:0]       wb_addr = '0;
  logic              wb_we = 1'b0;
  logic              wb_stb = 1'b0;
  logic              wb_cyc = 1'b0;
  logic [31:0]       wb_dout = '0;
  logic [31:0]       wb_din;
  logic              wb_ack;
  logic              spi_sck;
  logic              spi_mosi;
  logic              spi_miso = 1'b0;
  logic [NUM_SS-1:0] spi_ss;

  always #5 clk = ~clk;

  wb_spi_master #(
    .DATA_W (DATA_W),
    .NUM_SS (NUM_SS),
    .DIV_W  (DIV_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_addr  (wb_addr),
    .wb_we    (wb_we),
    .wb_stb   (wb_stb),
    .wb_cyc   (wb_cyc),
    .wb_dout  (wb_dout),
    .wb_din   (wb_din),
    .wb_ack   (wb_ack),
    .spi_sck  (spi_sck),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_ss   (spi_ss)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model of the programmed configuration and the transfer in flight.
  int          m_div = 0;
  int          m_len = DATA_W - 1;
  logic        m_cpol = 1'b0;
  logic        m_cpha = 1'b0;
  logic        m_ssm = 1'b0;
  logic [3:0]  m_sel = '0;
  logic [31:0] m_tx = '0;
  logic [31:0] m_rxw = '0;
  bit          m_arm = 1'b0;
  bit          m_active = 1'b0;
  int          m_t = 0;
  int          edge_cnt = 0;
  int          miso_idx = 0;
  int          last_edges = 0;
  logic [31:0] got = '0;
  logic [31:0] last_got = '0;
  logic        prev_sck = 1'b0;
  logic [31:0] rd_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ctrl_word(input int div, input bit cpol, input bit cpha,
                                            input bit ssm, input int sel, input int len);
    return 32'(div) | (32'(cpol) << 8) | (32'(cpha) << 9) | (32'(ssm) << 10) |
           (32'(sel) << 11) | (32'(len) << 19);
  endfunction

  always @(negedge clk) begin : cmp
    int          h;
    int          nb;
    int          dur;
    int          e;
    bit          fin;
    logic        lead;
    logic        ex_sck;
    logic [3:0]  ex_ss;
    logic [31:0] mask;
    if (rst) begin
      h   = m_div + 1;
      nb  = m_len + 1;
      dur = (2 * nb + 1) * h;
      fin = 1'b0;
      mask = (nb >= 32) ? 32'hFFFF_FFFF : ((32'd1 << nb) - 32'd1);
      if (m_arm) begin
        m_arm    = 1'b0;
        m_active = 1'b1;
        m_t      = 0;
        edge_cnt = 0;
        miso_idx = 0;
        got      = '0;
        prev_sck = m_cpol;
        if (!m_cpha) spi_miso = m_rxw[m_len];
      end else if (m_active) begin
        m_t++;
        if (m_t >= dur) begin
          m_active = 1'b0;
          fin      = 1'b1;
        end
      end

      ex_sck = m_cpol;
      if (m_active) begin
        e = m_t / h;
        if (e > 2 * nb) e = 2 * nb;
        ex_sck = m_cpol ^ e[0];
        if (spi_sck !== prev_sck) begin
          edge_cnt++;
          lead = (spi_sck !== m_cpol);
          if (lead != m_cpha) begin
            got = {got[30:0], spi_mosi};
          end else begin
            if (!m_cpha) miso_idx++;
            if (miso_idx <= m_len) spi_miso = m_rxw[m_len - miso_idx];
            if (m_cpha) miso_idx++;
          end
        end
        prev_sck = spi_sck;
      end

      ex_ss = (m_ssm || m_active) ? ~m_sel : 4'hF;
      chk("sck", {31'b0, spi_sck}, {31'b0, ex_sck});
      chk("ss", {28'b0, spi_ss}, {28'b0, ex_ss});

      if (fin) begin
        chk("mosi_word", got, m_tx & mask);
        chk("sck_edges", edge_cnt, 2 * nb);
        last_got   = got;
        last_edges = edge_cnt;
      end
    end
  end

  task automatic wb_xfer(input int a, input bit we, input logic [31:0] d, output logic [31:0] r);
    @(posedge clk); #1;
    wb_addr = 32'(a) << 2;
    wb_we   = we;
    wb_dout = d;
    wb_cyc  = 1'b1;
    wb_stb  = 1'b1;
    @(posedge clk); #1;
    chk("ack", {31'b0, wb_ack}, 32'd1);
    r = wb_din;
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    wb_we  = 1'b0;
    if (we && a == 0 && !m_active) begin
      m_div  = int'(d[7:0]);
      m_cpol = d[8];
      m_cpha = d[9];
      m_ssm  = d[10];
      m_sel  = d[14:11];
      m_len  = (d[23:19] >= 5'(DATA_W)) ? DATA_W - 1 : int'(d[23:19]);
    end
    if (we && a == 2 && !m_active) begin
      m_arm = 1'b1;
      m_tx  = d;
    end
    @(posedge clk); #1;
    chk("ack_single", {31'b0, wb_ack}, 32'd0);
  endtask

  task automatic rd_chk(input int a, input logic [31:0] exp, input string name);
    logic [31:0] r;
    wb_xfer(a, 1'b0, 32'd0, r);
    chk(name, r, exp);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_active || m_arm) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 5000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: transfer still active after %0d cycles", n);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic run_xfer(input logic [31:0] tx, input logic [31:0] rxw);
    logic [31:0] r;
    m_rxw = rxw;
    wb_xfer(2, 1'b1, tx, r);
    wait_idle();
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst      = 1'b0;
    m_arm    = 1'b0;
    m_active = 1'b0;
    m_div    = 0;
    m_len    = DATA_W - 1;
    m_cpol   = 1'b0;
    m_cpha   = 1'b0;
    m_ssm    = 1'b0;
    m_sel    = '0;
    spi_miso = 1'b0;
    #1;
    chk("rst_ack", {31'b0, wb_ack}, 32'd0);
    chk("rst_din", wb_din, 32'd0);
    chk("rst_sck", {31'b0, spi_sck}, 32'd0);
    chk("rst_mosi", {31'b0, spi_mosi}, 32'd0);
    chk("rst_ss", {28'b0, spi_ss}, 32'hF);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    apply_reset();
    rd_chk(1, 32'h0, "status_reset");
    rd_chk(0, 32'h0078_0000, "ctrl_reset");
    rd_chk(3, 32'h0, "rx_reset");

    // Mode 0, div 1, 8 bits on ss[0].
    wb_xfer(0, 1'b1, ctrl_word(1, 0, 0, 0, 1, 7), rd_val);
    run_xfer(32'hA5, 32'h3C);
    chk("mode0_mosi", last_got, 32'hA5);
    chk("mode0_edges", last_edges, 32'd16);
    rd_chk(1, 32'h2, "status_rxv");
    rd_chk(3, 32'h3C, "mode0_rx");
    rd_chk(1, 32'h0, "status_rxv_clr");

    for (int mode = 1; mode < 4; mode++) begin
      wb_xfer(0, 1'b1, ctrl_word(1, mode[1], mode[0], 0, 1, 7), rd_val);
      chk("idle_sck", {31'b0, spi_sck}, 32'(mode >> 1));
      run_xfer(32'h5A, 32'hC3);
      chk("mode_mosi", last_got, 32'h5A);
      rd_chk(3, 32'hC3, "mode_rx");
    end

    // 12-bit transfer at full speed.
    wb_xfer(0, 1'b1, ctrl_word(0, 0, 0, 0, 1, 11), rd_val);
    run_xfer(32'hABC, 32'h5E7);
    chk("len12_edges", last_edges, 32'd24);
    chk("len12_mosi", last_got, 32'hABC);
    rd_chk(3, 32'h5E7, "len12_rx");

    // Writes while busy: TX dropped with wr_err, CTRL ignored.
    wb_xfer(0, 1'b1, ctrl_word(1, 0, 0, 0, 2, 7), rd_val);
    m_rxw = 32'h96;
    wb_xfer(2, 1'b1, 32'h3C, rd_val);
    wb_xfer(2, 1'b1, 32'hFF, rd_val);
    wb_xfer(0, 1'b1, ctrl_word(3, 1, 1, 0, 8, 3), rd_val);
    rd_chk(1, 32'h5, "status_busy_err");
    wait_idle();
    chk("busy_mosi", last_got, 32'h3C);
    rd_chk(0, ctrl_word(1, 0, 0, 0, 2, 7), "ctrl_kept");
    wb_xfer(1, 1'b1, 32'h4, rd_val);
    rd_chk(1, 32'h2, "wr_err_clr");
    rd_chk(3, 32'h96, "busy_rx");

    // Over-long len clamps to a full DATA_W word.
    wb_xfer(0, 1'b1, ctrl_word(0, 0, 1, 0, 1, 31), rd_val);
    run_xfer(32'h1234, 32'hBEEF);
    chk("clamp_edges", last_edges, 32'd32);
    rd_chk(3, 32'hBEEF, "clamp_rx");

    // Unread RXDATA is overwritten by the next completion.
    wb_xfer(0, 1'b1, ctrl_word(0, 0, 0, 0, 1, 7), rd_val);
    run_xfer(32'h11, 32'h22);
    run_xfer(32'h33, 32'h44);
    rd_chk(3, 32'h44, "overwrite_rx");

    // Manual select stays asserted across back-to-back transfers.
    wb_xfer(0, 1'b1, ctrl_word(1, 0, 0, 1, 6, 7), rd_val);
    chk("manual_ss", {28'b0, spi_ss}, 32'h9);
    run_xfer(32'hC3, 32'h81);
    run_xfer(32'h7E, 32'h18);
    rd_chk(3, 32'h18, "manual_rx");

    // Reset in the middle of a transfer.
    wb_xfer(0, 1'b1, ctrl_word(1, 1, 0, 0, 1, 7), rd_val);
    m_rxw = 32'h77;
    wb_xfer(2, 1'b1, 32'hAA, rd_val);
    repeat (10) @(posedge clk);
    apply_reset();
    rd_chk(1, 32'h0, "status_after_abort");
    rd_chk(3, 32'h0, "rx_after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_spi_master.md
Name: wb_spi_master

Overview:
Parametrised Wishbone-slave SPI master that replaces the fixed-width Wishbone/SPI bridge pair.
- Adds a programmable SCK divider, all four CPOL/CPHA modes, variable transfer length up to DATA_W bits and NUM_SS one-hot slave selects.
- Chip-select control is automatic or manual.
- Sits on the peripheral Wishbone bus; drives the board SPI pins directly.

Parameters:
DATA_W, 8, maximum transfer width in bits (8..32)
NUM_SS, 4, number of active-low slave-select outputs (1..8)
DIV_W, 8, width of SCK divider field

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
wb_addr  in  32  byte address; only [3:2] decoded
wb_we  in  1  write enable
wb_stb  in  1  strobe
wb_cyc  in  1  cycle
wb_dout  in  32  bus-to-slave data
wb_din  out  32  slave-to-bus data
wb_ack  out  1  acknowledge
spi_sck  out  1  serial clock
spi_mosi  out  1  master out
spi_miso  in  1  master in
spi_ss  out  NUM_SS  active-low selects

Behaviour:
- Reset (rst low, async): wb_ack=0, wb_din=0, spi_sck=0, spi_mosi=0, spi_ss=all 1, FSM=IDLE; all register fields 0 except CTRL.len=DATA_W-1.
- Wishbone handshake: access when wb_cyc&wb_stb&!wb_ack. wb_ack asserts exactly one cycle later for one cycle; no back-to-back ack. Read data is registered with the ack.
- Register map (wb_addr[3:2]):
  - 0 CTRL rw: [DIV_W-1:0] div; [8] cpol; [9] cpha; [10] ss_manual; [18:11] ss_sel (one-hot, low NUM_SS bits used); [23:19] len = bits-1.
  - 1 STATUS: [0] busy ro; [1] rx_valid ro; [2] wr_err, sticky, write 1 to clear.
  - 2 TXDATA wo: write starts a transfer. Reads return 0.
  - 3 RXDATA ro: read returns rx word right-aligned, upper bits 0, and clears rx_valid.
- len clamping: len >= DATA_W is treated as DATA_W-1.
- Writes while busy:
  - TXDATA write: dropped; wr_err set; still acked.
  - CTRL write: acked but ignored.
- Half period: SCK half period = div+1 clk cycles; div=0 gives SCK=clk/2. Divider counter reloads at every edge event.
- FSM IDLE -> SETUP -> XFER -> HOLD -> IDLE.
  - IDLE: sck=cpol; busy=0.
  - TXDATA write: latch data, MSB-aligned at bit len; busy=1; go SETUP.
  - SETUP, one half period: ss_sel asserted unless ss_manual; for cpha=0 the MOSI first bit is driven here.
  - XFER: 2*(len+1) SCK edges.
    - cpha=0: sample MISO on leading edges, shift out on trailing edges.
    - cpha=1: shift out on leading edges, sample on trailing edges.
    - MSB first.
  - HOLD, one half period: sck returns to cpol; then ss deasserted unless ss_manual; rx_valid=1; busy=0 on return to IDLE.
- Manual ss: when ss_manual=1, spi_ss = ~ss_sel continuously, including in IDLE.
- rx_valid collision: a new transfer completing while rx_valid=1 overwrites RXDATA. If an RXDATA read coincides with completion, set wins.
- cpol change: takes effect on sck in IDLE on the cycle after the CTRL write.
- Reset mid-transfer: immediate abort to reset values; no partial rx_valid.

Decomposition:
- Package wb_spi_pkg holds:
  - register offsets (REG_CTRL=0, REG_STATUS=1, REG_TX=2, REG_RX=3);
  - CTRL bit positions;
  - FSM state encoding.
- One sub-module, spi_shift_engine, owns the divider, FSM, edge generation and shift register. Its handshake is start/len/cpol/cpha/div in; busy/done/rx out.
- The top level is the Wishbone register file plus ss muxing.

Test Plan:
- Reset during idle and mid-transfer -> all outputs at reset values within the same cycle; STATUS reads 0.
- CTRL=div 1, mode 0, ss_sel=0x1, len=7; TX=0xA5 with MISO echoing 0x3C -> 8 SCK periods of 4 clk each, MOSI 10100101, ss[0] low only during transfer, RXDATA=0x3C, rx_valid cleared after read.
- Repeat with modes 1, 2 and 3, TX=0x5A -> sck idle level equals cpol; sampling edge per cpha; RXDATA correct in each mode.
- DATA_W=16, len=11, TX=0xABC -> exactly 12 SCK pulses; RXDATA upper 20 bits 0.
- TX write while busy -> ack given, transfer unaffected, STATUS=0x5; write 0x4 to STATUS -> wr_err clears.
- ss_manual=1, ss_sel=0x6 -> spi_ss=4'b1001 across two consecutive transfers, never toggling between them.
